// File: rtl/lock_supervisor.sv
// lock_supervisor
//   Supervises a keypad-style sequence detector: forwards the raw X/Y
//   inputs to the detector, times each entry attempt, counts consecutive
//   failed attempts and enters a timed LOCKOUT once MAX_FAIL is reached.
//
// Parameters
//   MAX_FAIL    consecutive failures that trigger lockout (1..15)
//   ATTEMPT_CYC cycles allowed per entry attempt        (1..65535)
//   LOCKOUT_CYC cycles spent in lockout                 (1..65535)
//   RELOCK_CYC  cycles OPEN lasts before auto-relock     (1..65535)
//
// Ports
//   CLK, RESET            clock, synchronous active-high reset
//   X, Y                  raw user inputs
//   UNLOCK_IN             unlock indication from the detector
//   MANUAL_LOCK           user relock / abort request (level)
//   GATE_X, GATE_Y        X/Y forwarded to the detector, 0 in LOCKOUT
//   LOCK_OUT              registered detector-reset command
//   ALARM                 high while in LOCKOUT
//   OPEN_LED              high while in OPEN
//   FAIL_CNT[3:0]         consecutive-failure count
//
// Build option
//   LOCK_SUPERVISOR_AUTORELOCK_EN  when defined, OPEN relocks by itself
//   after RELOCK_CYC cycles (lowest priority in OPEN).

module lock_supervisor #(
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned ATTEMPT_CYC = 20,
  parameter int unsigned LOCKOUT_CYC = 50,
  parameter int unsigned RELOCK_CYC  = 30
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       X,
  input  logic       Y,
  input  logic       UNLOCK_IN,
  input  logic       MANUAL_LOCK,
  output logic       GATE_X,
  output logic       GATE_Y,
  output logic       LOCK_OUT,
  output logic       ALARM,
  output logic       OPEN_LED,
  output logic [3:0] FAIL_CNT
);

  if (MAX_FAIL < 1 || MAX_FAIL > 15) begin : g_bad_max_fail
    $error("lock_supervisor: MAX_FAIL out of range 1..15");
  end
  if (ATTEMPT_CYC < 1 || ATTEMPT_CYC > 65535) begin : g_bad_attempt
    $error("lock_supervisor: ATTEMPT_CYC out of range 1..65535");
  end
  if (LOCKOUT_CYC < 1 || LOCKOUT_CYC > 65535) begin : g_bad_lockout
    $error("lock_supervisor: LOCKOUT_CYC out of range 1..65535");
  end
  if (RELOCK_CYC < 1 || RELOCK_CYC > 65535) begin : g_bad_relock
    $error("lock_supervisor: RELOCK_CYC out of range 1..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ENTRY,
    S_OPEN,
    S_LOCKOUT
  } state_t;

  localparam logic [15:0] ATTEMPT_TC = 16'(ATTEMPT_CYC - 1);
  localparam logic [15:0] LOCKOUT_TC = 16'(LOCKOUT_CYC - 1);
`ifdef LOCK_SUPERVISOR_AUTORELOCK_EN
  localparam logic [15:0] RELOCK_TC  = 16'(RELOCK_CYC - 1);
`endif
  localparam logic [3:0]  FAIL_LIMIT = 4'(MAX_FAIL);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  fail_cnt_q, fail_cnt_d;
  logic        lock_out_q, lock_out_d;
  logic [3:0]  fail_next;

  assign fail_next = fail_cnt_q + 4'd1;

  // lock_out_d is the value LOCK_OUT takes in the cycle after this edge:
  // one-cycle pulses on abort/timeout/relock, held high through LOCKOUT
  // and released on the edge that leaves it.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    fail_cnt_d = fail_cnt_q;
    lock_out_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (X | Y) begin
          state_d = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (UNLOCK_IN) begin
          state_d    = S_OPEN;
          timer_d    = '0;
          fail_cnt_d = '0;
        end else if (MANUAL_LOCK) begin
          state_d    = S_IDLE;
          timer_d    = '0;
          lock_out_d = 1'b1;
        end else if (timer_q == ATTEMPT_TC) begin
          timer_d    = '0;
          fail_cnt_d = fail_next;
          lock_out_d = 1'b1;
          state_d    = (fail_next == FAIL_LIMIT) ? S_LOCKOUT : S_IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      S_OPEN: begin
        if (MANUAL_LOCK) begin
          state_d    = S_IDLE;
          timer_d    = '0;
          lock_out_d = 1'b1;
        end else if (!UNLOCK_IN) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
`ifdef LOCK_SUPERVISOR_AUTORELOCK_EN
          if (timer_q == RELOCK_TC) begin
            state_d    = S_IDLE;
            timer_d    = '0;
            lock_out_d = 1'b1;
          end else begin
            timer_d = timer_q + 16'd1;
          end
`else
          timer_d = '0;
`endif
        end
      end
      S_LOCKOUT: begin
        if (timer_q == LOCKOUT_TC) begin
          state_d    = S_IDLE;
          timer_d    = '0;
          fail_cnt_d = '0;
        end else begin
          timer_d    = timer_q + 16'd1;
          lock_out_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      fail_cnt_q <= '0;
      lock_out_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      fail_cnt_q <= fail_cnt_d;
      lock_out_q <= lock_out_d;
    end
  end

  assign GATE_X   = X & (state_q != S_LOCKOUT);
  assign GATE_Y   = Y & (state_q != S_LOCKOUT);
  assign LOCK_OUT = lock_out_q;
  assign ALARM    = (state_q == S_LOCKOUT);
  assign OPEN_LED = (state_q == S_OPEN);
  assign FAIL_CNT = fail_cnt_q;

endmodule

// File: tb/tb_lock_supervisor.sv
// tb_lock_supervisor
//   Directed vector table with hand-derived expectations, an OPEN hold
//   sequence, then randomized traffic compared against a countdown-based
//   behavioural model of the supervisor.

module tb_lock_supervisor;

  localparam int MAXF = 3;
  localparam int ATT  = 20;
  localparam int LKO  = 50;
  localparam int REL  = 30;

  logic       CLK = 1'b0;
  logic       RESET, X, Y, UNLOCK_IN, MANUAL_LOCK;
  logic       GATE_X, GATE_Y, LOCK_OUT, ALARM, OPEN_LED;
  logic [3:0] FAIL_CNT;

  int checks = 0;
  int errors = 0;

  lock_supervisor #(
    .MAX_FAIL   (MAXF),
    .ATTEMPT_CYC(ATT),
    .LOCKOUT_CYC(LKO),
    .RELOCK_CYC (REL)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .X          (X),
    .Y          (Y),
    .UNLOCK_IN  (UNLOCK_IN),
    .MANUAL_LOCK(MANUAL_LOCK),
    .GATE_X     (GATE_X),
    .GATE_Y     (GATE_Y),
    .LOCK_OUT   (LOCK_OUT),
    .ALARM      (ALARM),
    .OPEN_LED   (OPEN_LED),
    .FAIL_CNT   (FAIL_CNT)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: flags plus countdowns of remaining cycles.
  bit m_valid = 1'b0;
  bit m_in_attempt, m_is_open, m_locked, m_lock;
  int m_fails, m_att_left, m_lk_left;
`ifdef LOCK_SUPERVISOR_AUTORELOCK_EN
  int m_open_age;
`endif

  task automatic model_step(input bit r, input bit x, input bit y, input bit u, input bit m);
    if (r) begin
      m_valid = 1'b1; m_in_attempt = 1'b0; m_is_open = 1'b0; m_locked = 1'b0;
      m_fails = 0; m_lock = 1'b1;
      return;
    end
    m_lock = 1'b0;
    if (m_locked) begin
      m_lk_left--;
      if (m_lk_left == 0) begin
        m_locked = 1'b0; m_fails = 0;
      end else m_lock = 1'b1;
    end else if (m_in_attempt) begin
      if (u) begin
        m_in_attempt = 1'b0; m_is_open = 1'b1; m_fails = 0;
`ifdef LOCK_SUPERVISOR_AUTORELOCK_EN
        m_open_age = 0;
`endif
      end else if (m) begin
        m_in_attempt = 1'b0; m_lock = 1'b1;
      end else begin
        m_att_left--;
        if (m_att_left == 0) begin
          m_in_attempt = 1'b0; m_fails++; m_lock = 1'b1;
          if (m_fails == MAXF) begin
            m_locked = 1'b1; m_lk_left = LKO;
          end
        end
      end
    end else if (m_is_open) begin
      if (m) begin
        m_is_open = 1'b0; m_lock = 1'b1;
      end else if (!u) begin
        m_is_open = 1'b0;
      end else begin
`ifdef LOCK_SUPERVISOR_AUTORELOCK_EN
        m_open_age++;
        if (m_open_age == REL) begin
          m_is_open = 1'b0; m_lock = 1'b1;
        end
`endif
      end
    end else if (x | y) begin
      m_in_attempt = 1'b1; m_att_left = ATT;
    end
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, check the combinational gates, clock, then
  // compare registered outputs against the model.
  task automatic cycle(input bit r, input bit x, input bit y, input bit u, input bit m);
    RESET = r; X = x; Y = y; UNLOCK_IN = u; MANUAL_LOCK = m;
    #1;
    if (m_valid) begin
      check("model.gate_x", {3'b0, GATE_X}, {3'b0, x & !m_locked});
      check("model.gate_y", {3'b0, GATE_Y}, {3'b0, y & !m_locked});
    end
    @(posedge CLK);
    model_step(r, x, y, u, m);
    #1;
    check("model.lock_out", {3'b0, LOCK_OUT}, {3'b0, m_lock});
    check("model.alarm",    {3'b0, ALARM},    {3'b0, m_locked});
    check("model.open_led", {3'b0, OPEN_LED}, {3'b0, m_is_open});
    check("model.fail_cnt", FAIL_CNT, 4'(m_fails));
  endtask

  typedef struct {
    bit         r, x, y, u, m;
    int         n;
    bit         e_open, e_alarm, e_lock;
    logic [3:0] e_fail;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input bit r, input bit x, input bit y, input bit u, input bit m,
                              input int n, input bit eo, input bit ea, input bit el,
                              input logic [3:0] ef);
    vec_t v;
    v.r = r; v.x = x; v.y = y; v.u = u; v.m = m; v.n = n;
    v.e_open = eo; v.e_alarm = ea; v.e_lock = el; v.e_fail = ef;
    tbl.push_back(v);
  endfunction

  // Failed attempt starting in IDLE with fail count f-1; leaves fail count f.
  function automatic void fail_attempt(input int f, input bit use_y);
    logic [3:0] pf = 4'(f - 1);
    logic [3:0] nf = 4'(f);
    bit lk = (f == MAXF);
    add(0, !use_y, use_y, 0, 0, 1,      0, 0,  0, pf);
    add(0, 0, 0, 0, 0, ATT - 1,         0, 0,  0, pf);
    add(0, 0, 0, 0, 0, 1,               0, lk, 1, nf);
    add(0, 0, 0, 0, 0, 1,               0, lk, lk, nf);
  endfunction

  initial begin
    RESET = 1'b1; X = 1'b0; Y = 1'b0; UNLOCK_IN = 1'b0; MANUAL_LOCK = 1'b0;

    // reset
    add(1, 0, 0, 0, 0, 2,       0, 0, 1, 0);
    // success on ENTRY cycle 10
    add(0, 1, 0, 0, 0, 1,       0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 10,      0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1,       1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 5,       1, 0, 0, 0);
    add(0, 0, 0, 1, 1, 1,       0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1,       0, 0, 0, 0);
    // three timeouts -> lockout, X ignored, exit clears count
    fail_attempt(1, 0);
    fail_attempt(2, 1);
    fail_attempt(3, 0);
    add(0, 1, 1, 1, 1, LKO - 2, 0, 1, 1, 3);
    add(0, 0, 0, 0, 0, 1,       0, 0, 0, 0);
    // unlock + manual on the timeout cycle -> OPEN, count cleared
    fail_attempt(1, 0);
    add(0, 1, 0, 0, 0, 1,       0, 0, 0, 1);
    add(0, 0, 0, 0, 0, ATT - 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 1, 1,       1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 1,       0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1,       0, 0, 0, 0);
    // manual abort keeps the count
    fail_attempt(1, 1);
    add(0, 0, 1, 0, 0, 1,       0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 5,       0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1,       0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1,       0, 0, 0, 1);
    // two failures, success, detector relock, then three more to lock out
    fail_attempt(2, 0);
    add(0, 1, 0, 0, 0, 1,       0, 0, 0, 2);
    add(0, 0, 0, 1, 0, 1,       1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,       0, 0, 0, 0);
    fail_attempt(1, 0);
    fail_attempt(2, 0);
    fail_attempt(3, 1);
    // reset at lockout cycle 25
    add(0, 0, 0, 0, 0, 24,      0, 1, 1, 3);
    add(1, 0, 0, 0, 0, 1,       0, 0, 1, 0);
    add(1, 1, 0, 0, 0, 2,       0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1,       0, 0, 0, 0);

    for (int unsigned i = 0; i < tbl.size(); i++) begin
      for (int k = 0; k < tbl[i].n; k++)
        cycle(tbl[i].r, tbl[i].x, tbl[i].y, tbl[i].u, tbl[i].m);
      check($sformatf("tbl[%0d].open", i),  {3'b0, OPEN_LED}, {3'b0, tbl[i].e_open});
      check($sformatf("tbl[%0d].alarm", i), {3'b0, ALARM},    {3'b0, tbl[i].e_alarm});
      check($sformatf("tbl[%0d].lock", i),  {3'b0, LOCK_OUT}, {3'b0, tbl[i].e_lock});
      check($sformatf("tbl[%0d].fail", i),  FAIL_CNT,         tbl[i].e_fail);
    end

    // OPEN held with UNLOCK_IN=1
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    check("hold.entered_open", {3'b0, OPEN_LED}, 4'd1);
`ifdef LOCK_SUPERVISOR_AUTORELOCK_EN
    for (int k = 0; k < REL - 1; k++) cycle(0, 0, 0, 1, 0);
    check("hold.open_before_relock", {3'b0, OPEN_LED}, 4'd1);
    check("hold.no_pulse_yet",       {3'b0, LOCK_OUT}, 4'd0);
    cycle(0, 0, 0, 1, 0);
    check("hold.relocked",     {3'b0, OPEN_LED}, 4'd0);
    check("hold.relock_pulse", {3'b0, LOCK_OUT}, 4'd1);
    cycle(0, 0, 0, 1, 0);
    check("hold.pulse_ends",   {3'b0, LOCK_OUT}, 4'd0);
`else
    for (int k = 0; k < 100; k++) cycle(0, 0, 0, 1, 0);
    check("hold.still_open_100", {3'b0, OPEN_LED}, 4'd1);
    check("hold.no_pulse",       {3'b0, LOCK_OUT}, 4'd0);
    cycle(0, 0, 0, 0, 0);
    check("hold.detector_relock", {3'b0, OPEN_LED}, 4'd0);
`endif

    // randomized traffic in blocks with varying input densities
    for (int b = 0; b < 20; b++) begin
      int unl_pct = ($urandom_range(0, 1) == 0) ? 2 : 35;
      int man_pct = ($urandom_range(0, 1) == 0) ? 1 : 8;
      int xy_pct  = int'($urandom_range(5, 40));
      for (int k = 0; k < 150; k++) begin
        bit r = ($urandom_range(0, 299) == 0);
        bit x = ($urandom_range(0, 99) < xy_pct);
        bit y = ($urandom_range(0, 99) < xy_pct);
        bit u = ($urandom_range(0, 99) < unl_pct);
        bit m = ($urandom_range(0, 99) < man_pct);
        cycle(r, x, y, u, m);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
